// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared types and defaults for the cache fill arbiter:
//                FSM state encoding, fill owner encoding, block geometry
//                and memory latency defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    // Default block geometry and memory timing
    localparam int BLOCK_WORDS_DFLT = 8;
    localparam int MEM_LAT_DFLT     = 4;

    // Byte-offset width inside a block (2 bytes per word)
    localparam int BLK_OFF_W = $clog2(2 * BLOCK_WORDS_DFLT);

    // Fill arbiter FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } fill_state_t;

    // Which cache owns the fill in progress
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/fill_grant_arb.sv
`default_nettype none
// ============================================================================
//  Module      : fill_grant_arb
//  Description : Grant decision for the fill arbiter. A pending write-through
//                store always wins; between the two miss requesters the
//                choice is fixed (D over I) or, with FAIR_ARB_EN defined,
//                round-robin via a pointer register that starts at D.
//  Config      : FAIR_ARB_EN - enables round-robin I/D miss arbitration
//  Revision    : 1.0 - initial release
// ============================================================================
module fill_grant_arb
    import cache_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_arb_en,
    input  logic   i_wr_req,
    input  logic   i_dmiss_req,
    input  logic   i_imiss_req,
    output logic   o_grant_wr,
    output logic   o_grant_fill,
    output owner_t o_owner
);

    logic w_any_miss;
    assign w_any_miss = i_dmiss_req | i_imiss_req;

    // Writes pre-empt fills; a fill is granted only when no write is pending
    assign o_grant_wr   = i_arb_en & i_wr_req;
    assign o_grant_fill = i_arb_en & ~i_wr_req & w_any_miss;

`ifdef FAIR_ARB_EN
    owner_t r_ptr;

    // On a tie the pointer picks the owner; otherwise the lone requester wins
    always_comb begin
        o_owner = OWN_I;
        if (i_dmiss_req && i_imiss_req)
            o_owner = r_ptr;
        else if (i_dmiss_req)
            o_owner = OWN_D;
    end

    // Pointer moves to the other cache after every fill grant
    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= OWN_D;
        else if (o_grant_fill)
            r_ptr <= (o_owner == OWN_D) ? OWN_I : OWN_D;
    end
`else
    logic w_unused_fixed;
    assign w_unused_fixed = clk ^ rst;

    // Fixed priority: D miss over I miss
    always_comb begin
        o_owner = i_dmiss_req ? OWN_D : OWN_I;
    end
`endif

endmodule : fill_grant_arb
`default_nettype wire

// File: rtl/cache_fill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_fill_arbiter
//  Description : Shares one pipelined main memory between I-cache fills,
//                D-cache fills and D-cache write-through stores. A granted
//                fill issues BLOCK_WORDS reads back to back and steers the
//                returning words to the owning cache with a word index.
//  Config      : FAIR_ARB_EN - round-robin I/D miss arbitration
//                (handled inside fill_grant_arb)
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_fill_arbiter
    import cache_pkg::*;
#(
    parameter int BLOCK_WORDS = BLOCK_WORDS_DFLT,
    parameter int ADDR_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           icache_miss_req,
    input  logic [ADDR_W-1:0]              icache_miss_addr,
    output logic                           icache_fill_valid,
    output logic                           icache_fill_done,
    input  logic                           dcache_miss_req,
    input  logic [ADDR_W-1:0]              dcache_miss_addr,
    output logic                           dcache_fill_valid,
    output logic                           dcache_fill_done,
    input  logic                           dcache_wr_req,
    input  logic [ADDR_W-1:0]              dcache_wr_addr,
    input  logic [15:0]                    dcache_wr_data,
    output logic                           dcache_wr_ack,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic [15:0]                    fill_data,
    output logic                           mem_en,
    output logic                           mem_wr,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [15:0]                    mem_wdata,
    input  logic [15:0]                    mem_rdata,
    input  logic                           mem_rvalid,
    output logic                           busy
);

    localparam int WIDX_W = $clog2(BLOCK_WORDS);
    localparam int CNT_W  = WIDX_W + 1;
    localparam int OFF_W  = WIDX_W + 1;

    localparam logic [CNT_W-1:0]  c_BLOCK_CNT = CNT_W'(BLOCK_WORDS);
    localparam logic [ADDR_W-1:0] c_BASE_MASK = ~ADDR_W'((1 << OFF_W) - 1);

    fill_state_t         r_state;
    owner_t              r_owner;
    logic [ADDR_W-1:0]   r_base;
    logic [CNT_W-1:0]    r_issue_cnt;
    logic [CNT_W-1:0]    r_ret_cnt;
    logic                r_mem_en;
    logic                r_mem_wr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [15:0]         r_mem_wdata;
    logic                r_wr_ack;
    logic                r_ifill_valid;
    logic                r_dfill_valid;
    logic                r_idone;
    logic                r_ddone;
    logic [WIDX_W-1:0]   r_fill_word;
    logic [15:0]         r_fill_data;
    logic                r_busy;

    logic                w_arb_en;
    logic                w_grant_wr;
    logic                w_grant_fill;
    owner_t              w_owner;
    logic [ADDR_W-1:0]   w_miss_addr;
    logic [ADDR_W-1:0]   w_miss_base;
    logic [ADDR_W-1:0]   w_issue_addr;
    logic                w_accept;

    assign w_arb_en = (r_state == ST_IDLE);

    fill_grant_arb u_grant (
        .clk          (clk),
        .rst          (rst),
        .i_arb_en     (w_arb_en),
        .i_wr_req     (dcache_wr_req),
        .i_dmiss_req  (dcache_miss_req),
        .i_imiss_req  (icache_miss_req),
        .o_grant_wr   (w_grant_wr),
        .o_grant_fill (w_grant_fill),
        .o_owner      (w_owner)
    );

    assign w_miss_addr = (w_owner == OWN_D) ? dcache_miss_addr : icache_miss_addr;
    assign w_miss_base = w_miss_addr & c_BASE_MASK;

    // Block base has zero offset bits, so OR-ing the word offset never carries
    assign w_issue_addr = r_base |
                          {{(ADDR_W-OFF_W){1'b0}}, r_issue_cnt[WIDX_W-1:0], 1'b0};

    // Returns are only taken while a fill is outstanding and not yet complete
    assign w_accept = ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) &&
                      mem_rvalid && (r_ret_cnt < c_BLOCK_CNT);

    // Main FSM with registered memory, fill and handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_owner       <= OWN_I;
            r_base        <= '0;
            r_issue_cnt   <= '0;
            r_ret_cnt     <= '0;
            r_mem_en      <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_wr_ack      <= 1'b0;
            r_ifill_valid <= 1'b0;
            r_dfill_valid <= 1'b0;
            r_idone       <= 1'b0;
            r_ddone       <= 1'b0;
            r_fill_word   <= '0;
            r_fill_data   <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_mem_en      <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_wr_ack      <= 1'b0;
            r_idone       <= 1'b0;
            r_ddone       <= 1'b0;
            r_ifill_valid <= w_accept && (r_owner == OWN_I);
            r_dfill_valid <= w_accept && (r_owner == OWN_D);

            if (w_accept) begin
                r_fill_data <= mem_rdata;
                r_fill_word <= r_ret_cnt[WIDX_W-1:0];
                r_ret_cnt   <= r_ret_cnt + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_grant_wr) begin
                        r_state     <= ST_WRITE;
                        r_mem_en    <= 1'b1;
                        r_mem_wr    <= 1'b1;
                        r_mem_addr  <= dcache_wr_addr;
                        r_mem_wdata <= dcache_wr_data;
                        r_wr_ack    <= 1'b1;
                        r_busy      <= 1'b1;
                    end else if (w_grant_fill) begin
                        // First read goes out in the same cycle the FSM enters ISSUE
                        r_state     <= ST_ISSUE;
                        r_owner     <= w_owner;
                        r_base      <= w_miss_base;
                        r_mem_en    <= 1'b1;
                        r_mem_addr  <= w_miss_base;
                        r_issue_cnt <= CNT_W'(1);
                        r_ret_cnt   <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                ST_ISSUE: begin
                    if (r_issue_cnt != c_BLOCK_CNT) begin
                        r_mem_en    <= 1'b1;
                        r_mem_addr  <= w_issue_addr;
                        r_issue_cnt <= r_issue_cnt + 1'b1;
                    end else if (r_ret_cnt == c_BLOCK_CNT) begin
                        r_state <= ST_DONE;
                        r_idone <= (r_owner == OWN_I);
                        r_ddone <= (r_owner == OWN_D);
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Final word is on fill_data this cycle
                    if (r_ret_cnt == c_BLOCK_CNT) begin
                        r_state <= ST_DONE;
                        r_idone <= (r_owner == OWN_I);
                        r_ddone <= (r_owner == OWN_D);
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_issue_cnt <= '0;
                    r_ret_cnt   <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign icache_fill_valid = r_ifill_valid;
    assign icache_fill_done  = r_idone;
    assign dcache_fill_valid = r_dfill_valid;
    assign dcache_fill_done  = r_ddone;
    assign dcache_wr_ack     = r_wr_ack;
    assign fill_word         = r_fill_word;
    assign fill_data         = r_fill_data;
    assign mem_en            = r_mem_en;
    assign mem_wr            = r_mem_wr;
    assign mem_addr          = r_mem_addr;
    assign mem_wdata         = r_mem_wdata;
    assign busy              = r_busy;

endmodule : cache_fill_arbiter
`default_nettype wire
